// File: rtl/sincronizador_vga.sv
`timescale 1ns/1ps
// VGA 640x480@60 timing: divides CLK by 2 into p_tick and runs h/v scan counters.
// Sync outputs are registered from the next-state counters, so they change on the same edge as pixel_X/pixel_Y.
module sincronizador_vga #(
    parameter int HD = 640,
    parameter int HF = 16,
    parameter int HR = 96,
    parameter int HB = 48,
    parameter int VD = 480,
    parameter int VF = 10,
    parameter int VR = 2,
    parameter int VB = 33
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       sincro_horiz,
    output logic       sincro_vert,
    output logic       p_tick,
    output logic [9:0] pixel_X,
    output logic [9:0] pixel_Y
);

    localparam logic [9:0] H_MAX        = 10'(HD + HF + HR + HB - 1);
    localparam logic [9:0] H_SYNC_START = 10'(HD + HF);
    localparam logic [9:0] H_SYNC_END   = 10'(HD + HF + HR - 1);
    localparam logic [9:0] V_MAX        = 10'(VD + VF + VR + VB - 1);
    localparam logic [9:0] V_SYNC_START = 10'(VD + VF);
    localparam logic [9:0] V_SYNC_END   = 10'(VD + VF + VR - 1);

    logic       mod2;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       h_sync_reg;
    logic       v_sync_reg;

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_end;
    logic       v_end;
    logic       h_sync_next;
    logic       v_sync_next;

    always_comb begin
        h_end  = (h_count == H_MAX);
        v_end  = (v_count == V_MAX);
        h_next = h_count;
        v_next = v_count;
        if (mod2) begin
            h_next = h_end ? 10'd0 : h_count + 10'd1;
            if (h_end) begin
                v_next = v_end ? 10'd0 : v_count + 10'd1;
            end
        end
        // Decode from the next-state value so sync lines up with the coordinate edge
        h_sync_next = (h_next >= H_SYNC_START) && (h_next <= H_SYNC_END);
        v_sync_next = (v_next >= V_SYNC_START) && (v_next <= V_SYNC_END);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mod2       <= 1'b0;
            h_count    <= 10'd0;
            v_count    <= 10'd0;
            h_sync_reg <= 1'b0;
            v_sync_reg <= 1'b0;
        end else begin
            mod2       <= ~mod2;
            h_count    <= h_next;
            v_count    <= v_next;
            h_sync_reg <= h_sync_next;
            v_sync_reg <= v_sync_next;
        end
    end

    assign p_tick       = mod2;
    assign pixel_X      = h_count;
    assign pixel_Y      = v_count;
    assign sincro_horiz = ~h_sync_reg;
    assign sincro_vert  = ~v_sync_reg;

endmodule

// File: tb/tb_sincronizador_vga.sv
`timescale 1ns/1ps
// Bench: full-size instance for horizontal timing, shrunk instance for vertical/frame behaviour,
// both compared each cycle against an edge-count arithmetic model.
module tb_sincronizador_vga;

    logic       CLK;
    logic       RESET;

    logic       hs_b, vs_b, pt_b;
    logic [9:0] px_b, py_b;
    logic       hs_s, vs_s, pt_s;
    logic [9:0] px_s, py_s;

    int n_cmp;
    int n_bad;
    int n;

    logic prev_hs_b, prev_vs_s, prev_pt_s;
    logic [9:0] prev_px_s, prev_py_s;
    int last_hfall, last_vfall;

    sincronizador_vga u_big (
        .CLK          (CLK),
        .RESET        (RESET),
        .sincro_horiz (hs_b),
        .sincro_vert  (vs_b),
        .p_tick       (pt_b),
        .pixel_X      (px_b),
        .pixel_Y      (py_b)
    );

    sincronizador_vga #(
        .HD(16), .HF(4), .HR(6), .HB(4),
        .VD(8),  .VF(2), .VR(2), .VB(3)
    ) u_small (
        .CLK          (CLK),
        .RESET        (RESET),
        .sincro_horiz (hs_s),
        .sincro_vert  (vs_s),
        .p_tick       (pt_s),
        .pixel_X      (px_s),
        .pixel_Y      (py_s)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".big.px"}, int'(px_b), 0);
        check({tag, ".big.py"}, int'(py_b), 0);
        check({tag, ".big.pt"}, int'(pt_b), 0);
        check({tag, ".big.hs"}, int'(hs_b), 1);
        check({tag, ".big.vs"}, int'(vs_b), 1);
        check({tag, ".small.px"}, int'(px_s), 0);
        check({tag, ".small.py"}, int'(py_s), 0);
        check({tag, ".small.pt"}, int'(pt_s), 0);
        check({tag, ".small.hs"}, int'(hs_s), 1);
        check({tag, ".small.vs"}, int'(vs_s), 1);
    endtask

    // After `edges` clock edges since reset release: p_tick = edges odd,
    // ticks completed = edges/2, position = tick count folded into the raster.
    task automatic check_model(input string nm, input int edges,
                               input int ht, input int vt,
                               input int hs0, input int hr, input int vs0, input int vr,
                               input logic hs, input logic vs, input logic pt,
                               input logic [9:0] px, input logic [9:0] py);
        int t, ex, ey;
        t  = edges / 2;
        ex = t % ht;
        ey = (t / ht) % vt;
        check({nm, ".pt"}, int'(pt), edges % 2);
        check({nm, ".px"}, int'(px), ex);
        check({nm, ".py"}, int'(py), ey);
        check({nm, ".hs"}, int'(hs), (ex >= hs0 && ex < hs0 + hr) ? 0 : 1);
        check({nm, ".vs"}, int'(vs), (ey >= vs0 && ey < vs0 + vr) ? 0 : 1);
    endtask

    task automatic restart_tracking();
        n          = 0;
        last_hfall = -1;
        last_vfall = -1;
        prev_hs_b  = hs_b;
        prev_vs_s  = vs_s;
        prev_pt_s  = pt_s;
        prev_px_s  = px_s;
        prev_py_s  = py_s;
    endtask

    task automatic step();
        @(posedge CLK);
        n++;
        @(negedge CLK);
        check_model("big",   n, 800, 525, 656, 96, 490, 2, hs_b, vs_b, pt_b, px_b, py_b);
        check_model("small", n, 30,  15,  20,  6,  10,  2, hs_s, vs_s, pt_s, px_s, py_s);

        if (prev_hs_b && !hs_b) begin
            check("hsync_fall_x", int'(px_b), 656);
            if (last_hfall >= 0) check("hsync_period", n - last_hfall, 1600);
            last_hfall = n;
        end
        if (!prev_hs_b && hs_b && last_hfall >= 0) begin
            check("hsync_width", n - last_hfall, 192);
            check("hsync_rise_x", int'(px_b), 752);
        end

        if (prev_vs_s && !vs_s) begin
            check("vsync_fall_y", int'(py_s), 10);
            check("vsync_fall_x", int'(px_s), 0);
            if (last_vfall >= 0) check("vsync_period", n - last_vfall, 900);
            last_vfall = n;
        end
        if (!prev_vs_s && vs_s && last_vfall >= 0) begin
            check("vsync_width", n - last_vfall, 120);
        end

        if (prev_px_s == 10'd29 && prev_py_s == 10'd14 && prev_pt_s) begin
            check("frame_wrap_x", int'(px_s), 0);
            check("frame_wrap_y", int'(py_s), 0);
        end

        prev_hs_b = hs_b;
        prev_vs_s = vs_s;
        prev_pt_s = pt_s;
        prev_px_s = px_s;
        prev_py_s = py_s;
    endtask

    initial begin
        int target_y;
        int budget;
        n_cmp = 0;
        n_bad = 0;

        RESET = 1'b0;
        #5;
        check_reset_outputs("reset_early");
        #48;
        check_reset_outputs("reset_clocked");
        while ($time < 100) @(negedge CLK);
        RESET = 1'b1;
        restart_tracking();

        // Four full lines on the full-size raster, many frames on the small one.
        repeat (6400) step();

        // Asynchronous reset mid-frame on the small raster, between clock edges.
        target_y = int'($urandom_range(3, 12));
        budget   = 1000;
        while (int'(py_s) != target_y && budget > 0) begin
            step();
            budget--;
        end
        check("midframe_reached", (budget > 0) ? 1 : 0, 1);
        @(posedge CLK);
        #($urandom_range(2, 8));
        RESET = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        repeat ($urandom_range(2, 5)) @(negedge CLK);
        check_reset_outputs("midframe_hold");
        RESET = 1'b1;
        restart_tracking();

        repeat (2000) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
